// File: rtl/inert_spi_seq_if.sv
// Command/response bus between the inertial sequencer (master) and the SPI monarch (slave).
interface inert_spi_seq_if;
   logic        wrt;
   logic [15:0] wt_data;
   logic        done;
   logic [15:0] rd_data;

   modport master (output wrt, output wt_data, input done, input rd_data);
   modport slave  (input wrt, input wt_data, output done, output rd_data);
endinterface

// File: rtl/inert_spi_seq.sv
// Inertial sensor SPI sequencer: power-up wait, four config writes, then INT-driven yaw reads.
// Optional macro YAW_OFFSET_EN subtracts YAW_OFFSET from the assembled yaw rate.
module inert_spi_seq #(
   parameter int                 PWRUP_W    = 16,
   parameter logic signed [15:0] YAW_OFFSET = 16'sh0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               INT,
   inert_spi_seq_if.master    bus,
   output logic signed [15:0] yaw_rt,
   output logic               vld,
   output logic               init_done
);

   typedef enum logic [3:0] {
      PWRUP, W1_ISS, W1_WT, W2_ISS, W2_WT, W3_ISS, W3_WT, W4_ISS, W4_WT,
      IDLE, RL_ISS, RL_WT, RH_ISS, RH_WT
   } state_t;

   // Leaving PWRUP on the edge that brings the counter to all ones gives 2^PWRUP_W-1 wait cycles.
   localparam logic [PWRUP_W-1:0] PWRUP_LAST = {{(PWRUP_W-1){1'b1}}, 1'b0};

   state_t             state, state_nxt;
   logic [PWRUP_W-1:0] pwrup_cnt;
   logic               int_s1, int_s2;
   logic [7:0]         lo_hold, lo_hold_nxt;
   logic               wrt_q, wrt_nxt;
   logic [15:0]        wt_data_q, wt_data_nxt;
   logic               vld_nxt, init_done_nxt;
   logic signed [15:0] yaw_nxt;
   logic               unused_rd_hi;

   assign bus.wrt      = wrt_q;
   assign bus.wt_data  = wt_data_q;
   assign unused_rd_hi = ^bus.rd_data[15:8];

   function automatic logic [15:0] cmd_word(input state_t s);
      case (s)
         W1_ISS:  return 16'h0D02;
         W2_ISS:  return 16'h1053;
         W3_ISS:  return 16'h1150;
         W4_ISS:  return 16'h1460;
         RL_ISS:  return 16'hA600;
         RH_ISS:  return 16'hA700;
         default: return 16'h0000;
      endcase
   endfunction

`ifdef YAW_OFFSET_EN
   function automatic logic signed [15:0] apply_offset(input logic signed [15:0] raw);
      return raw - YAW_OFFSET;
   endfunction
`else
   function automatic logic signed [15:0] apply_offset(input logic signed [15:0] raw);
      return raw;
   endfunction
   logic unused_offset;
   assign unused_offset = ^YAW_OFFSET;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= PWRUP;
         pwrup_cnt <= '0;
         int_s1    <= 1'b0;
         int_s2    <= 1'b0;
      end else begin
         state  <= state_nxt;
         int_s1 <= INT;
         int_s2 <= int_s1;
         if (state == PWRUP && !(&pwrup_cnt))
            pwrup_cnt <= pwrup_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         PWRUP:   if (pwrup_cnt == PWRUP_LAST) state_nxt = W1_ISS;
         W1_ISS:  state_nxt = W1_WT;
         W1_WT:   if (bus.done) state_nxt = W2_ISS;
         W2_ISS:  state_nxt = W2_WT;
         W2_WT:   if (bus.done) state_nxt = W3_ISS;
         W3_ISS:  state_nxt = W3_WT;
         W3_WT:   if (bus.done) state_nxt = W4_ISS;
         W4_ISS:  state_nxt = W4_WT;
         W4_WT:   if (bus.done) state_nxt = IDLE;
         IDLE:    if (int_s2) state_nxt = RL_ISS;
         RL_ISS:  state_nxt = RL_WT;
         RL_WT:   if (bus.done) state_nxt = RH_ISS;
         RH_ISS:  state_nxt = RH_WT;
         RH_WT:   if (bus.done) state_nxt = IDLE;
         default: state_nxt = PWRUP;
      endcase
   end

   // Outputs are registered from the upcoming state so wrt and wt_data are aligned with each issue state.
   always_comb begin
      wrt_nxt       = 1'b0;
      wt_data_nxt   = wt_data_q;
      lo_hold_nxt   = lo_hold;
      vld_nxt       = 1'b0;
      yaw_nxt       = yaw_rt;
      init_done_nxt = init_done;
      case (state_nxt)
         W1_ISS, W2_ISS, W3_ISS, W4_ISS, RL_ISS, RH_ISS: begin
            wrt_nxt     = 1'b1;
            wt_data_nxt = cmd_word(state_nxt);
         end
         default: ;
      endcase
      if (bus.done) begin
         case (state)
            W4_WT: init_done_nxt = 1'b1;
            RL_WT: lo_hold_nxt   = bus.rd_data[7:0];
            RH_WT: begin
               vld_nxt = 1'b1;
               yaw_nxt = apply_offset($signed({bus.rd_data[7:0], lo_hold}));
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrt_q     <= 1'b0;
         wt_data_q <= 16'h0000;
         lo_hold   <= 8'h00;
         vld       <= 1'b0;
         yaw_rt    <= 16'sh0000;
         init_done <= 1'b0;
      end else begin
         wrt_q     <= wrt_nxt;
         wt_data_q <= wt_data_nxt;
         lo_hold   <= lo_hold_nxt;
         vld       <= vld_nxt;
         yaw_rt    <= yaw_nxt;
         init_done <= init_done_nxt;
      end
   end

endmodule

// File: doc/inert_spi_seq.md
Name: inert_spi_seq

Overview:
Transaction sequencer sitting directly upstream of the SPI monarch. After reset it waits for sensor power-up, then writes four gyro/accel configuration registers. After that it loops forever: it waits for the sensor's data-ready interrupt, reads yaw-rate low and high bytes, and presents a 16-bit signed yaw rate with a one-cycle valid pulse. It drives the monarch's wrt/wt_data and consumes its done/rd_data; the yaw output feeds the heading integrator.

Parameters:
PWRUP_W, 16, width of power-up delay counter; init starts when the counter reaches all ones (2^PWRUP_W-1 cycles); benches override to 4.
YAW_OFFSET, 16'sh0000, signed constant subtracted from raw yaw (used only with YAW_OFFSET_EN).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
INT  in  1  sensor data-ready interrupt, asynchronous, active high
done  in  1  SPI monarch transaction complete (level, sticky until next wrt)
rd_data  in  16  SPI monarch read data; low byte valid for reads
wrt  out  1  one-cycle pulse starting an SPI transaction
wt_data  out  16  command word to SPI monarch, held stable while waiting for done
yaw_rt  out  16  signed yaw rate {high byte, low byte}
vld  out  1  one-cycle pulse, yaw_rt updated
init_done  out  1  high once all config writes have completed

Behaviour:
- Reset: wrt=0, wt_data=16'h0000, yaw_rt=16'h0000, vld=0, init_done=0, state=PWRUP, power-up counter=0, INT synchronizer flops=0, low-byte holding register=0. All registers use the async reset.
- INT passes through a 2-flop synchronizer. Only the synchronized level is used; it is level sensitive, not edge sensitive.
- wrt handshake:
  - In an issue state, wrt=1 for exactly one cycle; wt_data is registered in that same cycle.
  - The monarch clears done on the edge after wrt.
  - The sequencer then sits in the matching wait state until done=1, and advances on that cycle.
  - A wrt is never issued while a transaction is outstanding.
- Command words:
  - CFG1=16'h0D02 (INT on data-ready)
  - CFG2=16'h1053 (accel 208Hz)
  - CFG3=16'h1150 (gyro 208Hz)
  - CFG4=16'h1460 (rounding on)
  - RDL=16'hA600 (yaw low)
  - RDH=16'hA700 (yaw high)
- States:
  - PWRUP: counter increments every cycle; at all ones go to W1_ISS. The counter saturates and is not reused.
  - Wn_ISS (n=1..4): pulse wrt with CFGn, go to Wn_WT.
  - Wn_WT: on done go to W(n+1)_ISS. From W4_WT, set init_done=1 and go to IDLE.
  - IDLE: if synchronized INT=1, go to RL_ISS.
  - RL_ISS: pulse wrt with RDL, go to RL_WT.
  - RL_WT: on done, capture rd_data[7:0] into the low holding register, go to RH_ISS.
  - RH_ISS: pulse wrt with RDH, go to RH_WT.
  - RH_WT: on done, yaw_rt <= {rd_data[7:0], low_hold} (minus offset if enabled), vld=1 for that one cycle, go to IDLE.
- INT assertion during any non-IDLE state is ignored. If INT is still high on return to IDLE, a new read starts the next cycle, so back-to-back reads are permitted.
- yaw_rt holds its value between vld pulses; it changes only on the vld cycle.
- Per-sample latency: IDLE-with-INT to vld = 4 sequencer cycles plus two SPI transaction durations.
- init_done never deasserts except on reset.
- Reset mid-transaction: everything returns to PWRUP and the full config sequence reruns. A stale done=1 seen in PWRUP or IDLE is ignored.

Optional Feature:
YAW_OFFSET_EN
- Defined: yaw_rt = {hi,lo} - YAW_OFFSET, 16-bit two's-complement, wrapping (no saturation).
- Undefined: yaw_rt = {hi,lo} raw, and YAW_OFFSET is unused.
- Timing and vld are identical either way.

Test Plan:
- Reset with PWRUP_W=4, done model responds 20 cycles after each wrt -> first wrt 15 cycles after reset release; exactly four wrt pulses with wt_data 0D02, 1053, 1150, 1460 in order; init_done rises in the cycle after the 4th done; no further wrt while INT=0.
- After init, pulse INT high 3 cycles; model returns rd_data=16'h00CD for A600 and 16'h00AB for A700 -> wt_data A600 then A700, yaw_rt=16'hABCD, one vld pulse.
- Hold INT high continuously with fixed response bytes 34/12 -> repeated read pairs with no gap beyond one IDLE cycle; yaw_rt=16'h1234 and one vld per pair.
- INT pulses during the W2_WT wait state -> ignored; no A600 issued until after init_done.
- Assert rst_n low during RH_WT -> all outputs return to reset values immediately; the sequence restarts with 0D02 after the power-up delay.
- YAW_OFFSET_EN defined, YAW_OFFSET=16'sh0010, raw 16'h0005 -> yaw_rt=16'hFFF5.
